// File: rtl/alu_rs_sched.sv
// ALU/branch reservation station: CDB wakeup, dispatch bypass, one issue per cycle.
// Define ALU_RS_OLDEST_FIRST_EN for oldest-first selection via an age matrix; default is lowest-index.
module alu_rs_sched #(
  parameter int DEPTH     = 8,
  parameter int ROB_IDX_W = 4,
  parameter int OPT_W     = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rdy,
  input  logic                 flush,
  input  logic                 issue_st,
  input  logic                 disp_valid,
  input  logic [OPT_W-1:0]     disp_opt,
  input  logic [31:0]          disp_val1,
  input  logic [31:0]          disp_val2,
  input  logic [ROB_IDX_W-1:0] disp_q1,
  input  logic [ROB_IDX_W-1:0] disp_q2,
  input  logic [31:0]          disp_imm,
  input  logic [ROB_IDX_W-1:0] disp_rob_idx,
  output logic                 rs_full,
  input  logic                 cdb_alu_valid,
  input  logic                 cdb_lsb_valid,
  input  logic [ROB_IDX_W-1:0] cdb_alu_src,
  input  logic [ROB_IDX_W-1:0] cdb_lsb_src,
  input  logic [31:0]          cdb_alu_val,
  input  logic [31:0]          cdb_lsb_val,
  output logic                 rs_valid,
  output logic [OPT_W-1:0]     rs_opt,
  output logic [31:0]          rs_val1,
  output logic [31:0]          rs_val2,
  output logic [31:0]          rs_imm,
  output logic [ROB_IDX_W-1:0] rs_rob_idx
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic                 busy;
    logic [OPT_W-1:0]     opt;
    logic [31:0]          val1;
    logic [ROB_IDX_W-1:0] q1;
    logic [31:0]          val2;
    logic [ROB_IDX_W-1:0] q2;
    logic [31:0]          imm;
    logic [ROB_IDX_W-1:0] rob_idx;
  } ent_t;

  ent_t           ent     [DEPTH];
  ent_t           ent_nxt [DEPTH];
  logic [DEPTH-1:0] busy, ready, pick, issue_oh;
  logic [IW-1:0]  sel, fsel;
  logic [CW-1:0]  count, count_nxt;
  logic           issue_go, disp_go;

  // Returns {q, val} after snooping both CDBs; ALU CDB wins a tag collision.
  function automatic logic [ROB_IDX_W+31:0] wake(input logic [ROB_IDX_W-1:0] q,
                                                 input logic [31:0] v);
    if (q != '0 && cdb_alu_valid && q == cdb_alu_src)
      return {{ROB_IDX_W{1'b0}}, cdb_alu_val};
    else if (q != '0 && cdb_lsb_valid && q == cdb_lsb_src)
      return {{ROB_IDX_W{1'b0}}, cdb_lsb_val};
    else
      return {q, v};
  endfunction

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      busy[i]  = ent[i].busy;
      ready[i] = ent[i].busy && ent[i].q1 == '0 && ent[i].q2 == '0;
    end
  end

`ifdef ALU_RS_OLDEST_FIRST_EN
  // age[i][j] set means entry j was already waiting when entry i arrived.
  logic [DEPTH-1:0] age     [DEPTH];
  logic [DEPTH-1:0] age_nxt [DEPTH];

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      pick[i]    = ready[i] && ((age[i] & ready) == '0);
      age_nxt[i] = age[i] & ~issue_oh;
      if (disp_go && fsel == IW'(i)) age_nxt[i] = busy & ~issue_oh;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) age[i] <= '0;
    end else if (rdy) begin
      for (int i = 0; i < DEPTH; i++) age[i] <= flush ? '0 : age_nxt[i];
    end
  end
`else
  always_comb pick = ready;
`endif

  always_comb begin
    sel  = '0;
    fsel = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (pick[i]) sel = IW'(i);
      if (!busy[i]) fsel = IW'(i);
    end
    issue_go = !issue_st && (|ready);
    disp_go  = disp_valid && !rs_full;
    for (int i = 0; i < DEPTH; i++) issue_oh[i] = issue_go && sel == IW'(i);
    count_nxt = count + {{(CW-1){1'b0}}, disp_go} - {{(CW-1){1'b0}}, issue_go};
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_nxt[i] = ent[i];
      {ent_nxt[i].q1, ent_nxt[i].val1} = wake(ent[i].q1, ent[i].val1);
      {ent_nxt[i].q2, ent_nxt[i].val2} = wake(ent[i].q2, ent[i].val2);
      if (issue_oh[i]) ent_nxt[i].busy = 1'b0;
      if (disp_go && fsel == IW'(i)) begin
        ent_nxt[i].busy    = 1'b1;
        ent_nxt[i].opt     = disp_opt;
        ent_nxt[i].imm     = disp_imm;
        ent_nxt[i].rob_idx = disp_rob_idx;
        {ent_nxt[i].q1, ent_nxt[i].val1} = wake(disp_q1, disp_val1);
        {ent_nxt[i].q2, ent_nxt[i].val2} = wake(disp_q2, disp_val2);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
      count      <= '0;
      rs_full    <= 1'b0;
      rs_valid   <= 1'b0;
      rs_opt     <= '0;
      rs_val1    <= '0;
      rs_val2    <= '0;
      rs_imm     <= '0;
      rs_rob_idx <= '0;
    end else if (rdy) begin
      if (flush) begin
        for (int i = 0; i < DEPTH; i++) ent[i].busy <= 1'b0;
        count    <= '0;
        rs_full  <= 1'b0;
        rs_valid <= 1'b0;
      end else begin
        for (int i = 0; i < DEPTH; i++) ent[i] <= ent_nxt[i];
        count    <= count_nxt;
        rs_full  <= (count_nxt == CW'(DEPTH));
        rs_valid <= issue_go;
        if (issue_go) begin
          rs_opt     <= ent[sel].opt;
          rs_val1    <= ent[sel].val1;
          rs_val2    <= ent[sel].val2;
          rs_imm     <= ent[sel].imm;
          rs_rob_idx <= ent[sel].rob_idx;
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_rs_sched.sv
// Directed bench for alu_rs_sched (DEPTH=8); follows ALU_RS_OLDEST_FIRST_EN for the ordering case.
module tb_alu_rs_sched;
  logic        clk = 0, rst_n = 0, rdy = 1, flush = 0, issue_st = 0;
  logic        disp_valid = 0;
  logic [5:0]  disp_opt = 0;
  logic [31:0] disp_val1 = 0, disp_val2 = 0, disp_imm = 0;
  logic [3:0]  disp_q1 = 0, disp_q2 = 0, disp_rob_idx = 0;
  logic        rs_full, rs_valid;
  logic        cdb_alu_valid = 0, cdb_lsb_valid = 0;
  logic [3:0]  cdb_alu_src = 0, cdb_lsb_src = 0;
  logic [31:0] cdb_alu_val = 0, cdb_lsb_val = 0;
  logic [5:0]  rs_opt;
  logic [31:0] rs_val1, rs_val2, rs_imm;
  logic [3:0]  rs_rob_idx;
  int n_chk = 0, n_fail = 0;

  localparam logic [5:0] ADD = 6'd1, ADDI = 6'd10;

  alu_rs_sched dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .flush(flush), .issue_st(issue_st),
    .disp_valid(disp_valid), .disp_opt(disp_opt), .disp_val1(disp_val1), .disp_val2(disp_val2),
    .disp_q1(disp_q1), .disp_q2(disp_q2), .disp_imm(disp_imm), .disp_rob_idx(disp_rob_idx),
    .rs_full(rs_full), .cdb_alu_valid(cdb_alu_valid), .cdb_lsb_valid(cdb_lsb_valid),
    .cdb_alu_src(cdb_alu_src), .cdb_lsb_src(cdb_lsb_src), .cdb_alu_val(cdb_alu_val),
    .cdb_lsb_val(cdb_lsb_val), .rs_valid(rs_valid), .rs_opt(rs_opt), .rs_val1(rs_val1),
    .rs_val2(rs_val2), .rs_imm(rs_imm), .rs_rob_idx(rs_rob_idx));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic disp(input logic [5:0] opt, input logic [3:0] q1, input logic [31:0] v1,
                      input logic [3:0] q2, input logic [31:0] v2, input logic [31:0] imm,
                      input logic [3:0] rob);
    disp_valid = 1; disp_opt = opt; disp_q1 = q1; disp_val1 = v1;
    disp_q2 = q2; disp_val2 = v2; disp_imm = imm; disp_rob_idx = rob;
  endtask

  task automatic cdb_alu(input logic v, input logic [3:0] src, input logic [31:0] val);
    cdb_alu_valid = v; cdb_alu_src = src; cdb_alu_val = val;
  endtask

  task automatic cdb_lsb(input logic v, input logic [3:0] src, input logic [31:0] val);
    cdb_lsb_valid = v; cdb_lsb_src = src; cdb_lsb_val = val;
  endtask

  initial begin
    // reset values
    #12;
    chk("rst_valid", rs_valid, 0); chk("rst_full", rs_full, 0); chk("rst_opt", rs_opt, 0);
    chk("rst_val1", rs_val1, 0);   chk("rst_imm", rs_imm, 0);   chk("rst_rob", rs_rob_idx, 0);
    rst_n = 1;
    tick();

    // single ready op
    disp(ADD, 0, 5, 0, 7, 0, 3);
    tick(); disp_valid = 0;
    chk("single_not_yet", rs_valid, 0);
    tick();
    chk("single_valid", rs_valid, 1); chk("single_val1", rs_val1, 5);
    chk("single_val2", rs_val2, 7);   chk("single_rob", rs_rob_idx, 3);
    chk("single_opt", rs_opt, ADD);
    tick();
    chk("single_drop", rs_valid, 0); chk("single_hold", rs_val1, 5);

    // CDB wakeup
    disp(ADDI, 2, 0, 0, 0, 1, 4);
    tick(); disp_valid = 0;
    tick(); chk("wake_blocked", rs_valid, 0);
    cdb_lsb(1, 2, 32'h10);
    tick(); cdb_lsb(0, 0, 0);
    chk("wake_latency", rs_valid, 0);
    tick();
    chk("wake_valid", rs_valid, 1); chk("wake_val1", rs_val1, 32'h10);
    chk("wake_imm", rs_imm, 1);     chk("wake_rob", rs_rob_idx, 4);
    tick();

    // dispatch bypass from same-cycle CDB
    disp(ADDI, 2, 0, 0, 0, 1, 5);
    cdb_lsb(1, 2, 32'h10);
    tick(); disp_valid = 0; cdb_lsb(0, 0, 0);
    tick();
    chk("byp_valid", rs_valid, 1); chk("byp_val1", rs_val1, 32'h10);
    chk("byp_imm", rs_imm, 1);     chk("byp_rob", rs_rob_idx, 5);
    tick();

    // ALU CDB wins a tag collision
    disp(ADD, 0, 3, 6, 0, 0, 2);
    cdb_alu(1, 6, 32'hA); cdb_lsb(1, 6, 32'hB);
    tick(); disp_valid = 0; cdb_alu(0, 0, 0); cdb_lsb(0, 0, 0);
    tick();
    chk("prio_valid", rs_valid, 1); chk("prio_val2", rs_val2, 32'hA);
    tick();

    // fill, drop, drain
    for (int i = 0; i < 8; i++) begin
      disp(ADD, 5, 0, 0, 2, 0, 4'(i + 1));
      tick();
      if (i == 6) chk("fill_not_full", rs_full, 0);
    end
    chk("fill_full", rs_full, 1);
    disp(ADD, 0, 9, 0, 9, 0, 9);
    tick(); disp_valid = 0;
    chk("drop_full", rs_full, 1); chk("drop_noissue", rs_valid, 0);
    cdb_alu(1, 5, 32'h55);
    tick(); cdb_alu(0, 0, 0);
    chk("drain_latency", rs_valid, 0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("drain_valid", rs_valid, 1);
      chk("drain_rob", rs_rob_idx, 32'(i + 1));
      chk("drain_val1", rs_val1, 32'h55);
      if (i == 0) chk("drain_full_fall", rs_full, 0);
    end
    tick(); chk("drain_empty", rs_valid, 0);

    // selection order: entry 1 older than entry 0
    disp(ADD, 0, 1, 0, 1, 0, 12);
    tick();
    disp(ADD, 4, 0, 0, 0, 0, 11);
    tick(); chk("ord_pre_issue", rs_rob_idx, 12);
    disp(ADD, 4, 0, 0, 0, 0, 10);
    tick(); disp_valid = 0;
    chk("ord_blocked", rs_valid, 0);
    cdb_alu(1, 4, 32'h44);
    tick(); cdb_alu(0, 0, 0);
    tick();
    chk("ord_first_valid", rs_valid, 1);
`ifdef ALU_RS_OLDEST_FIRST_EN
    chk("ord_first", rs_rob_idx, 11);
`else
    chk("ord_first", rs_rob_idx, 10);
`endif
    tick();
    chk("ord_second_valid", rs_valid, 1);
`ifdef ALU_RS_OLDEST_FIRST_EN
    chk("ord_second", rs_rob_idx, 10);
`else
    chk("ord_second", rs_rob_idx, 11);
`endif
    tick(); chk("ord_done", rs_valid, 0);

    // rdy low freezes: dispatch ignored
    rdy = 0;
    disp(ADD, 0, 1, 0, 1, 0, 3);
    tick(); rdy = 1; disp_valid = 0;
    tick(); chk("rdy_frozen", rs_valid, 0);

    // stall
    issue_st = 1;
    disp(ADD, 0, 1, 0, 1, 0, 6);
    tick(); disp_valid = 0;
    tick(); chk("stall_hold", rs_valid, 0);
    issue_st = 0;
    tick();
    chk("stall_release", rs_valid, 1); chk("stall_rob", rs_rob_idx, 6);
    tick();

    // flush with dispatch
    for (int i = 0; i < 7; i++) begin
      disp(ADD, 7, 0, 0, 0, 0, 4'(i + 1));
      tick();
    end
    chk("fl_pre_full", rs_full, 0);
    flush = 1;
    disp(ADD, 0, 1, 0, 1, 0, 13);
    tick(); flush = 0; disp_valid = 0;
    chk("fl_full", rs_full, 0); chk("fl_valid", rs_valid, 0);
    tick(); chk("fl_discard", rs_valid, 0);
    for (int i = 0; i < 8; i++) begin
      disp(ADD, 7, 0, 0, 0, 0, 4'(i + 1));
      tick();
      if (i == 6) chk("fl_count7", rs_full, 0);
    end
    disp_valid = 0;
    chk("fl_count8", rs_full, 1);
    cdb_alu(1, 7, 32'h77);
    tick(); cdb_alu(0, 0, 0);
    tick();
    chk("ar_pre_valid", rs_valid, 1); chk("ar_pre_rob", rs_rob_idx, 1);

    // async reset between edges
    #2 rst_n = 0;
    #1;
    chk("ar_valid", rs_valid, 0); chk("ar_rob", rs_rob_idx, 0); chk("ar_full", rs_full, 0);
    #2 rst_n = 1;
    tick(); chk("ar_empty1", rs_valid, 0);
    tick(); chk("ar_empty2", rs_valid, 0); chk("ar_empty_full", rs_full, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
